// File: rtl/fir_stim_gen.sv
// fir_stim_gen: burst stimulus source for the FIR filter harness.
// On an accepted start it emits BURST_LEN signed samples, one every DIV clocks,
// each flagged by a one-cycle ready strobe, then pulses done for one cycle.
// Patterns: impulse, step, ramp, or 24-bit Galois LFSR.
module fir_stim_gen #(
    parameter int                       WIDTH       = 24,
    parameter int                       DIV         = 4,
    parameter int                       BURST_LEN   = 64,
    parameter logic signed [WIDTH-1:0]  IMPULSE_AMP = 24'h100000,
    parameter logic [23:0]              SEED        = 24'h00ACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic signed [WIDTH-1:0]  input_sig,
    output logic                     ready,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_mode;
    logic [DW-1:0]            r_div_cnt;
    logic [SW-1:0]            r_smp_cnt;
    logic [23:0]              r_lfsr;
    logic signed [WIDTH-1:0]  r_sig;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;

    // Galois right-shift step for x^24+x^23+x^22+x^17+1 (maximal length).
    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        lfsr_next = {1'b0, s[23:1]} ^ (s[0] ? 24'hE10000 : 24'h000000);
    endfunction

    // Value of sample k for the latched pattern; lf is the current LFSR state.
    function automatic logic signed [WIDTH-1:0] sample_val(
        input logic [1:0]     m,
        input logic [SW-1:0]  k,
        input logic [23:0]    lf
    );
        case (m)
            2'd0:    sample_val = (k == '0) ? IMPULSE_AMP : '0;
            2'd1:    sample_val = IMPULSE_AMP;
            2'd2:    sample_val = WIDTH'(k);
            default: sample_val = WIDTH'(lf);
        endcase
    endfunction

    // Burst sequencer: state, counters, LFSR and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'd0;
            r_div_cnt <= '0;
            r_smp_cnt <= '0;
            r_lfsr    <= SEED;
            r_sig     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sig  <= '0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_mode    <= mode;
                        r_div_cnt <= '0;
                        r_smp_cnt <= '0;
                        r_lfsr    <= SEED;
                    end
                end
                S_RUN: begin
                    // busy rises on the first edge spent in RUN, one cycle after acceptance
                    r_busy <= 1'b1;
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        r_sig     <= sample_val(r_mode, r_smp_cnt, r_lfsr);
                        r_ready   <= 1'b1;
                        r_lfsr    <= lfsr_next(r_lfsr);
                        if (r_smp_cnt == SMP_LAST) begin
                            r_state <= S_FIN;
                        end else begin
                            r_smp_cnt <= r_smp_cnt + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    // last sample was presented in the previous cycle; close the burst
                    r_sig   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign input_sig = r_sig;
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen: directed + randomized bench for fir_stim_gen.
// Three instances: DIV=4/BURST_LEN=8, DIV=2/BURST_LEN=2, DIV=3/BURST_LEN=1.
module tb_fir_stim_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
    logic [1:0] mode = 2'd0;

    logic signed [23:0] sig1, sig2, sig3;
    logic rdy1, rdy2, rdy3, bsy1, bsy2, bsy3, dn1, dn2, dn3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] lfsr_seq [0:15];

    always #5 clk = ~clk;

    fir_stim_gen #(.WIDTH(24), .DIV(4), .BURST_LEN(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode),
        .input_sig(sig1), .ready(rdy1), .busy(bsy1), .done(dn1));

    fir_stim_gen #(.WIDTH(24), .DIV(2), .BURST_LEN(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode),
        .input_sig(sig2), .ready(rdy2), .busy(bsy2), .done(dn2));

    fir_stim_gen #(.WIDTH(24), .DIV(3), .BURST_LEN(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode),
        .input_sig(sig3), .ready(rdy3), .busy(bsy3), .done(dn3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input int which);
        return (which == 1) ? 4 : (which == 2) ? 2 : 3;
    endfunction

    function automatic int bl_of(input int which);
        return (which == 1) ? 8 : (which == 2) ? 2 : 1;
    endfunction

    function automatic logic [23:0] exp_sample(input logic [1:0] m, input int k);
        case (m)
            2'd0:    return (k == 0) ? 24'h100000 : 24'h000000;
            2'd1:    return 24'h100000;
            2'd2:    return 24'(k);
            default: return lfsr_seq[k];
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            1: start1 = v;
            2: start2 = v;
            default: start3 = v;
        endcase
    endtask

    // Compare one instance's outputs against the burst timeline at offset n from the accepting edge.
    task automatic chk_cycle(input int which, input logic [1:0] m, input int n, input string tag);
        int d, b;
        logic [23:0] e_sig, o_sig;
        logic e_rdy, e_bsy, e_dn, o_rdy, o_bsy, o_dn;
        d = div_of(which);
        b = bl_of(which);
        e_rdy = (n >= d) && (n % d == 0) && (n <= d * b);
        e_bsy = (n >= 1) && (n <= d * b);
        e_dn  = (n == d * b + 1);
        e_sig = ((n >= d) && (n <= d * b)) ? exp_sample(m, n / d - 1) : 24'h0;
        case (which)
            1: begin o_sig = sig1; o_rdy = rdy1; o_bsy = bsy1; o_dn = dn1; end
            2: begin o_sig = sig2; o_rdy = rdy2; o_bsy = bsy2; o_dn = dn2; end
            default: begin o_sig = sig3; o_rdy = rdy3; o_bsy = bsy3; o_dn = dn3; end
        endcase
        chk($sformatf("%s d%0d n=%0d sig", tag, which, n), o_sig, e_sig);
        chk($sformatf("%s d%0d n=%0d ready", tag, which, n), {23'd0, o_rdy}, {23'd0, e_rdy});
        chk($sformatf("%s d%0d n=%0d busy", tag, which, n), {23'd0, o_bsy}, {23'd0, e_bsy});
        chk($sformatf("%s d%0d n=%0d done", tag, which, n), {23'd0, o_dn}, {23'd0, e_dn});
    endtask

    // Accept a burst, scramble mode afterwards, and check every cycle until back in IDLE.
    task automatic run_burst(input int which, input logic [1:0] m, input string tag);
        int last;
        last = div_of(which) * bl_of(which) + 2;
        set_start(which, 1'b1);
        mode = m;
        tick();
        set_start(which, 1'b0);
        mode = 2'($urandom_range(0, 3));
        chk_cycle(which, m, 0, tag);
        for (int n = 1; n <= last; n++) begin
            tick();
            if (n == 5) mode = 2'($urandom_range(0, 3));
            chk_cycle(which, m, n, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] s;
        logic [23:0] cap [0:7];
        int nrdy, ndone, k;
        logic [1:0] rm;

        s = 24'h00ACE1;
        for (int i = 0; i < 16; i++) begin
            lfsr_seq[i] = s;
            s = (s >> 1) ^ ((s % 2 == 1) ? 24'hE10000 : 24'h000000);
        end

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst sig1", sig1, 24'h0);
        chk("rst ready1", {23'd0, rdy1}, 24'h0);
        chk("rst busy1", {23'd0, bsy1}, 24'h0);
        chk("rst done1", {23'd0, dn1}, 24'h0);
        chk("rst sig2", sig2, 24'h0);
        chk("rst busy3", {23'd0, bsy3}, 24'h0);
        rst = 1'b0;
        tick();

        // 1 impulse, 2 ramp, step
        run_burst(1, 2'd0, "impulse");
        run_burst(1, 2'd2, "ramp");
        run_burst(1, 2'd1, "step");

        // 3 LFSR with captured samples against fixed reference values
        start1 = 1'b1;
        mode = 2'd3;
        tick();
        start1 = 1'b0;
        k = 0;
        chk_cycle(1, 2'd3, 0, "lfsr");
        for (int n = 1; n <= 34; n++) begin
            tick();
            chk_cycle(1, 2'd3, n, "lfsr");
            if (rdy1 && k < 8) begin
                cap[k] = sig1;
                k++;
            end
        end
        chk("lfsr count", 24'(k), 24'd8);
        chk("lfsr s0", cap[0], 24'h00ACE1);
        chk("lfsr s1", cap[1], 24'hE15670);
        chk("lfsr s2", cap[2], 24'h70AB38);

        // 4 start re-pulsed mid-burst with mode toggled
        start1 = 1'b1;
        mode = 2'd0;
        tick();
        start1 = 1'b0;
        nrdy = 0;
        ndone = 0;
        chk_cycle(1, 2'd0, 0, "restart");
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n <= 34) chk_cycle(1, 2'd0, n, "restart");
            nrdy += int'(rdy1);
            ndone += int'(dn1);
            if (n == 9) begin start1 = 1'b1; mode = 2'd2; end
            if (n == 10) begin start1 = 1'b0; mode = 2'd3; end
        end
        chk("restart readys", 24'(nrdy), 24'd8);
        chk("restart dones", 24'(ndone), 24'd1);

        // 5 reset after the third ready, then a full burst from a clean seed
        start1 = 1'b1;
        mode = 2'd3;
        tick();
        start1 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            chk_cycle(1, 2'd3, n, "midrst");
        end
        rst = 1'b1;
        tick();
        chk("midrst sig", sig1, 24'h0);
        chk("midrst ready", {23'd0, rdy1}, 24'h0);
        chk("midrst busy", {23'd0, bsy1}, 24'h0);
        chk("midrst done", {23'd0, dn1}, 24'h0);
        rst = 1'b0;
        tick();
        chk("midrst nodone", {23'd0, dn1}, 24'h0);
        run_burst(1, 2'd3, "after_rst");

        // 6 start held high: back-to-back bursts on DIV=2, BURST_LEN=2
        start2 = 1'b1;
        mode = 2'd2;
        tick();
        for (int n = 0; n <= 11; n++) begin
            if (n > 0) tick();
            chk_cycle(2, 2'd2, (n < 6) ? n : n - 6, "held");
            if (n == 11) start2 = 1'b0;
        end
        tick();
        chk("held idle busy", {23'd0, bsy2}, 24'h0);
        chk("held idle ready", {23'd0, rdy2}, 24'h0);

        // single-sample bursts
        run_burst(3, 2'd0, "bl1");
        run_burst(3, 2'd3, "bl1");

        // randomized bursts with random idle gaps
        for (int i = 0; i < 8; i++) begin
            rm = 2'($urandom_range(0, 3));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick();
                chk("gap busy1", {23'd0, bsy1}, 24'h0);
                chk("gap sig3", sig3, 24'h0);
            end
            case ($urandom_range(1, 3))
                1: run_burst(1, rm, "rand");
                2: run_burst(2, rm, "rand");
                default: run_burst(3, rm, "rand");
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
